ultrasonic_ranger_mc: RTL and testbench

- Multi-channel ultrasonic range finder for the car's sensor front end (e.g. left/centre/right sonar heads).
- Fires each channel's trigger in round-robin order, so only one head is active at a time and there is no acoustic crosstalk.
- Times each echo in millimetres, handles missing or over-long echoes with a timeout, and publishes per-channel binary distances with a valid strobe.
- Feeds the display/BCD block and the steering control logic.

---
 rtl/ultrasonic_ranger_mc_pkg.sv | 31 +++
 rtl/ultrasonic_ranger_mc_echo_sync_edge.sv | 41 ++++
 rtl/ultrasonic_ranger_mc.sv | 213 +++++++++++++++++++++
 tb/tb_ultrasonic_ranger_mc.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ultrasonic_ranger_mc_pkg.sv
// ultrasonic_ranger_mc_pkg
//   Definitions shared by the sonar ranger and the display/BCD block:
//   - FSM state encoding
//   - default 50 MHz timing constants
//   - distance-width helper
package ultrasonic_ranger_mc_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_MEASURE   = 3'd3,
    S_DONE      = 3'd4,
    S_GAP       = 3'd5
  } state_t;

  localparam int unsigned CLK_HZ          = 50_000_000;
  localparam int unsigned CH_NUM_DEF      = 3;
  localparam int unsigned TRIG_CYC_DEF    = 625;        // 12.5 us
  localparam int unsigned CYC_PER_MM_DEF  = 289;        // round trip folded in
  localparam int unsigned MAX_MM_DEF      = 4000;
  localparam int unsigned RISE_TO_CYC_DEF = 1_000_000;  // 20 ms
  localparam int unsigned GAP_CYC_DEF     = 2_500_000;  // 50 ms
  localparam int unsigned DIST_W_DEF      = 13;

  // Smallest width that holds 0..max_mm.
  function automatic int unsigned dist_w_min(input int unsigned max_mm);
    return $clog2(max_mm + 1);
  endfunction

endpackage

// File: rtl/ultrasonic_ranger_mc_echo_sync_edge.sv
// echo_sync_edge
//   Per-bit two-flop synchroniser followed by a registered edge detector.
//   A pad edge shows up as a one-cycle rise/fall pulse three cycles later.
//   Both edges have the same latency, so pulse spacing equals pad width.
// Ports:
//   iclk  system clock
//   rst   synchronous active-high reset
//   d     asynchronous inputs [W]
//   rise  one-cycle pulse on low->high [W]
//   fall  one-cycle pulse on high->low [W]
module echo_sync_edge
  import ultrasonic_ranger_mc_pkg::*;
#(
  parameter int unsigned W = CH_NUM_DEF
) (
  input  logic         iclk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] s1, s2, s3;

  always_ff @(posedge iclk) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      s3   <= '0;
      rise <= '0;
      fall <= '0;
    end else begin
      s1   <= d;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
      fall <= ~s2 & s3;
    end
  end

endmodule

// File: rtl/ultrasonic_ranger_mc.sv
// ultrasonic_ranger_mc
//   Round-robin multi-channel ultrasonic ranger. Fires one trigger at a time,
//   times the selected echo in mm, saturates/times out at MAX_MM and publishes
//   per-channel distances with a one-cycle valid strobe.
//   Optional macro MEDIAN3_EN: stores the median of the last 3 raw samples
//   per channel (first two samples after reset are stored raw).
// Ports:
//   iclk        system clock (50 MHz)
//   rst         synchronous active-high reset
//   en          run enable; dropping it lets the current cycle finish, then idle
//   echo        raw asynchronous echo inputs [CH_NUM]
//   trig        trigger outputs, one-hot or zero [CH_NUM]
//   dist_flat   latched mm per channel, channel k at [k*DIST_W +: DIST_W]
//   timeout     last sample of channel k timed out [CH_NUM]
//   dist_valid  one-cycle pulse when a channel result updates
//   dist_ch     channel index updated with dist_valid
module ultrasonic_ranger_mc
  import ultrasonic_ranger_mc_pkg::*;
#(
  parameter int unsigned CH_NUM      = CH_NUM_DEF,
  parameter int unsigned TRIG_CYC    = TRIG_CYC_DEF,
  parameter int unsigned CYC_PER_MM  = CYC_PER_MM_DEF,
  parameter int unsigned MAX_MM      = MAX_MM_DEF,
  parameter int unsigned RISE_TO_CYC = RISE_TO_CYC_DEF,
  parameter int unsigned GAP_CYC     = GAP_CYC_DEF,
  parameter int unsigned DIST_W      = DIST_W_DEF
) (
  input  logic                     iclk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [CH_NUM-1:0]        echo,
  output logic [CH_NUM-1:0]        trig,
  output logic [CH_NUM*DIST_W-1:0] dist_flat,
  output logic [CH_NUM-1:0]        timeout,
  output logic                     dist_valid,
  output logic [2:0]               dist_ch
);

  localparam int unsigned T_A   = (RISE_TO_CYC > GAP_CYC) ? RISE_TO_CYC : GAP_CYC;
  localparam int unsigned T_MAX = (T_A > TRIG_CYC) ? T_A : TRIG_CYC;
  localparam int unsigned TW    = $clog2(T_MAX + 1);
  localparam int unsigned SW    = $clog2(CYC_PER_MM + 1);

  state_t                        state, nstate;
  logic [TW-1:0]                 tcnt;
  logic [SW-1:0]                 sub;
  logic [DIST_W-1:0]             mm_cnt;
  logic [2:0]                    ptr;
  logic [CH_NUM-1:0]             rise_v, fall_v;
  logic                          rise_p, fall_p;
  logic                          trig_end, rise_to, sat, gap_end, carry, wr;
  logic                          sample_to;
  logic [DIST_W-1:0]             sample_mm, store_mm;
  logic [CH_NUM-1:0][DIST_W-1:0] dist_q;

  echo_sync_edge #(.W(CH_NUM)) u_sync (
    .iclk (iclk),
    .rst  (rst),
    .d    (echo),
    .rise (rise_v),
    .fall (fall_v)
  );

  // Only the active channel's edges are observed.
  always_comb begin
    rise_p = 1'b0;
    fall_p = 1'b0;
    for (int i = 0; i < CH_NUM; i++)
      if (ptr == 3'(i)) begin
        rise_p = rise_v[i];
        fall_p = fall_v[i];
      end
  end

  assign trig_end = (state == S_TRIG)      && (tcnt == TW'(TRIG_CYC - 1));
  assign rise_to  = (state == S_WAIT_RISE) && !rise_p && (tcnt == TW'(RISE_TO_CYC - 1));
  assign sat      = (state == S_MEASURE)   && (mm_cnt == DIST_W'(MAX_MM));
  assign gap_end  = (state == S_GAP)       && (tcnt == TW'(GAP_CYC - 1));
  assign carry    = (sub == SW'(CYC_PER_MM - 1));

  // State register
  always_ff @(posedge iclk) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  // Next state. Saturation is checked before the fall so a coincident fall
  // still reports a timeout.
  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:      if (en) nstate = S_TRIG;
      S_TRIG:      if (trig_end) nstate = S_WAIT_RISE;
      S_WAIT_RISE: if (rise_p) nstate = S_MEASURE;
                   else if (rise_to) nstate = S_DONE;
      S_MEASURE:   if (sat || fall_p) nstate = S_DONE;
      S_DONE:      nstate = S_GAP;
      S_GAP:       if (gap_end) nstate = en ? S_TRIG : S_IDLE;
      default:     nstate = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    trig       = '0;
    dist_valid = (state == S_DONE);
    dist_ch    = '0;
    if (state == S_TRIG)
      for (int i = 0; i < CH_NUM; i++) trig[i] = (ptr == 3'(i));
    if (state == S_DONE) dist_ch = ptr;
  end

  // Timers, mm counters and channel pointer
  always_ff @(posedge iclk) begin
    if (rst) begin
      tcnt   <= '0;
      sub    <= '0;
      mm_cnt <= '0;
      ptr    <= '0;
    end else begin
      if (nstate != state)
        tcnt <= '0;
      else if (state == S_TRIG || state == S_WAIT_RISE || state == S_GAP)
        tcnt <= tcnt + TW'(1);

      if (state == S_WAIT_RISE && rise_p) begin
        sub    <= '0;
        mm_cnt <= '0;
      end else if (state == S_MEASURE) begin
        if (carry) begin
          sub    <= '0;
          mm_cnt <= mm_cnt + DIST_W'(1);
        end else begin
          sub <= sub + SW'(1);
        end
      end

      if (gap_end) ptr <= (ptr == 3'(CH_NUM - 1)) ? 3'd0 : ptr + 3'd1;
    end
  end

  // The counters cover the cycles after the rise up to the one before the fall;
  // the fall cycle itself is folded in through carry so the result is
  // floor(width / CYC_PER_MM).
  assign sample_to = (state == S_WAIT_RISE) || sat;
  assign sample_mm = sample_to ? DIST_W'(MAX_MM) : mm_cnt + DIST_W'(carry);
  assign wr        = rise_to || ((state == S_MEASURE) && (sat || fall_p));

`ifdef MEDIAN3_EN
  logic [CH_NUM-1:0][DIST_W-1:0] h1_q, h2_q;   // newest, older raw samples
  logic [CH_NUM-1:0][1:0]        fill_q;
  logic [DIST_W-1:0]             h1_p, h2_p;
  logic [1:0]                    fill_p;

  function automatic logic [DIST_W-1:0] med3(input logic [DIST_W-1:0] a,
                                             input logic [DIST_W-1:0] b,
                                             input logic [DIST_W-1:0] c);
    logic [DIST_W-1:0] lo, hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    return (c < lo) ? lo : ((c > hi) ? hi : c);
  endfunction

  always_comb begin
    h1_p   = '0;
    h2_p   = '0;
    fill_p = '0;
    for (int i = 0; i < CH_NUM; i++)
      if (ptr == 3'(i)) begin
        h1_p   = h1_q[i];
        h2_p   = h2_q[i];
        fill_p = fill_q[i];
      end
  end

  assign store_mm = (fill_p == 2'd2) ? med3(h1_p, h2_p, sample_mm) : sample_mm;

  always_ff @(posedge iclk) begin
    if (rst) begin
      h1_q   <= '0;
      h2_q   <= '0;
      fill_q <= '0;
    end else if (wr) begin
      for (int i = 0; i < CH_NUM; i++)
        if (ptr == 3'(i)) begin
          h1_q[i] <= sample_mm;
          h2_q[i] <= h1_q[i];
          if (fill_q[i] != 2'd2) fill_q[i] <= fill_q[i] + 2'd1;
        end
    end
  end
`else
  assign store_mm = sample_mm;
`endif

  // Results land on the edge into DONE, so dist_flat is already current while
  // dist_valid is high.
  always_ff @(posedge iclk) begin
    if (rst) begin
      dist_q  <= '0;
      timeout <= '0;
    end else if (wr) begin
      for (int i = 0; i < CH_NUM; i++)
        if (ptr == 3'(i)) begin
          dist_q[i]  <= store_mm;
          timeout[i] <= sample_to;
        end
    end
  end

  assign dist_flat = dist_q;

endmodule

// File: tb/tb_ultrasonic_ranger_mc.sv
module tb_ultrasonic_ranger_mc;
  localparam int CH = 3, TRIG = 10, CPM = 5, MAXM = 400, RTO = 300, GAP = 50, DW = 13;
  localparam int N = 13;
  localparam int DLY = 20;

  logic              iclk = 1'b0;
  logic              rst, en;
  logic [CH-1:0]     echo, trig, timeout;
  logic [CH*DW-1:0]  dist_flat;
  logic              dist_valid;
  logic [2:0]        dist_ch;

  int errors = 0, checks = 0;

  always #5 iclk = ~iclk;

  ultrasonic_ranger_mc #(
    .CH_NUM(CH), .TRIG_CYC(TRIG), .CYC_PER_MM(CPM), .MAX_MM(MAXM),
    .RISE_TO_CYC(RTO), .GAP_CYC(GAP), .DIST_W(DW)
  ) dut (
    .iclk(iclk), .rst(rst), .en(en), .echo(echo), .trig(trig),
    .dist_flat(dist_flat), .timeout(timeout), .dist_valid(dist_valid), .dist_ch(dist_ch)
  );

  // Measurement n (n-th trigger fired) gets echo width w_tab[n] (0 = no echo).
  // d_tab/t_tab/c_tab are hand-computed expected results (entry 10 is cut by reset).
  int c_tab[N] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 0, 1};
`ifdef MEDIAN3_EN
  int w_tab[N] = '{500, 250, 1000, 1500, 0, 2500, 600, 100, 2000, 550, 150, 60, 30};
  int d_tab[N] = '{100, 50, 200, 300, 400, 400, 120, 50, 400, 120, 0, 12, 6};
  int t_tab[N] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
`else
  int w_tab[N] = '{500, 250, 1000, 50, 0, 2500, 2001, 100, 2000, 7, 150, 60, 30};
  int d_tab[N] = '{100, 50, 200, 10, 400, 400, 400, 20, 400, 1, 0, 12, 6};
  int t_tab[N] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0};
`endif

  task automatic chk(input string name, input int idx, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %0d expected %0d", name, idx, $time, act, exp);
    end
  endtask

  // ---------------- echo responders: one per sonar head ----------------
  int fire_cnt = 0;
  for (genvar k = 0; k < CH; k++) begin : g_resp
    logic e = 1'b0;
    assign echo[k] = e;
    initial begin
      int w;
      forever begin
        @(negedge iclk);
        while (trig[k] !== 1'b1) @(negedge iclk);
        while (trig[k] === 1'b1) @(negedge iclk);
        w = (fire_cnt - 1 < N) ? w_tab[fire_cnt - 1] : 0;
        repeat (DLY) @(negedge iclk);
        if (w > 0) begin
          e = 1'b1;
          repeat (w) @(negedge iclk);
          e = 1'b0;
        end
      end
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  logic          rst_q = 1'b0;
  logic          armed = 1'b0;
  logic [CH-1:0] trig_q = '0;
  int            exp_ch = 0, last_ch = 0, cur_ent = 0;
  int            tw[CH];
  int            mdl_d[CH], mdl_t[CH];
  int            hist[CH][2];
  int            hn[CH];

  always @(posedge iclk) rst_q <= rst;

  task automatic model_update(input int c, input int ent);
    int w, raw, to;
    int q[$];
    w   = (ent < N) ? w_tab[ent] : 0;
    to  = (w == 0 || w > MAXM * CPM) ? 1 : 0;
    raw = to ? MAXM : w / CPM;
`ifdef MEDIAN3_EN
    if (hn[c] >= 2) begin
      q = {hist[c][0], hist[c][1], raw};
      q.sort();
      mdl_d[c] = q[1];
    end else begin
      mdl_d[c] = raw;
    end
    hist[c][0] = hist[c][1];
    hist[c][1] = raw;
    if (hn[c] < 2) hn[c]++;
`else
    q = {};
    mdl_d[c] = raw;
`endif
    mdl_t[c] = to;
  endtask

  initial begin
    forever begin
      @(negedge iclk);
      if (rst_q) begin
        for (int k = 0; k < CH; k++) begin
          mdl_d[k] = 0; mdl_t[k] = 0; hn[k] = 0; hist[k][0] = 0; hist[k][1] = 0; tw[k] = 0;
        end
        exp_ch = 0;
        trig_q = '0;
        armed  = 1'b1;
      end
      if (armed) begin
        chk("trig_multi_hot", 0, ($countones(trig) > 1) ? 1 : 0, 0);
        for (int k = 0; k < CH; k++) begin
          if (trig[k] && !trig_q[k]) begin
            chk("trig_order", fire_cnt, k, exp_ch);
            exp_ch  = (exp_ch + 1) % CH;
            last_ch = k;
            cur_ent = fire_cnt;
            fire_cnt++;
            tw[k] = 0;
          end
          if (trig[k]) tw[k]++;
          if (!trig[k] && trig_q[k]) chk("trig_width", k, tw[k], TRIG);
        end
        trig_q = trig;
        if (dist_valid) begin
          chk("dist_ch", cur_ent, dist_ch, last_ch);
          model_update(last_ch, cur_ent);
        end
        for (int k = 0; k < CH; k++) begin
          chk("dist_model", k, dist_flat[k*DW +: DW], mdl_d[k]);
          chk("timeout_model", k, timeout[k], mdl_t[k]);
        end
      end
    end
  end

  // ---------------- directed sequence with literal expectations ----------------
  task automatic wait_valid(output int ch);
    int n;
    n  = 0;
    ch = -1;
    do begin
      @(negedge iclk);
      n++;
    end while (!dist_valid && n < 6000);
    checks++;
    if (!dist_valid) begin
      errors++;
      $display("FAIL wait_valid: no dist_valid within %0d cycles", n);
    end else begin
      ch = int'(dist_ch);
    end
  endtask

  task automatic run_one(input int i);
    int ch;
    wait_valid(ch);
    if (ch >= 0) begin
      chk("lit_ch", i, ch, c_tab[i]);
      chk("lit_dist", i, dist_flat[ch*DW +: DW], d_tab[i]);
      chk("lit_timeout", i, timeout[ch], t_tab[i]);
    end
  endtask

  initial begin
    int n, seen;
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge iclk);
    chk("rst_trig", 0, trig, 0);
    chk("rst_dist", 0, dist_flat, 0);
    chk("rst_timeout", 0, timeout, 0);
    chk("rst_valid", 0, dist_valid, 0);
    chk("rst_dist_ch", 0, dist_ch, 0);
    @(posedge iclk); #1;
    rst = 1'b0;
    en  = 1'b1;

    for (int i = 0; i < 10; i++) run_one(i);

    // reset in the middle of measurement 10 (ch1)
    n = 0;
    while (fire_cnt < 11 && n < 6000) begin
      @(negedge iclk);
      n++;
    end
    chk("fire10_seen", 0, (fire_cnt >= 11) ? 1 : 0, 1);
    repeat (133) @(posedge iclk);
    #1 rst = 1'b1;
    @(posedge iclk);
    @(negedge iclk);
    chk("rst_mid_trig", 0, trig, 0);
    chk("rst_mid_dist", 0, dist_flat, 0);
    chk("rst_mid_timeout", 0, timeout, 0);
    @(posedge iclk); #1;
    rst = 1'b0;

    run_one(11);

    // drop en during GAP: no further trigger while idle
    repeat (5) @(posedge iclk);
    #1 en = 1'b0;
    seen = 0;
    repeat (300) begin
      @(negedge iclk);
      if (trig != '0 || dist_valid) seen++;
    end
    chk("idle_no_activity", 0, seen, 0);
    en = 1'b1;

    run_one(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
